trigger_measure: RTL and testbench

TRIGGER_MEASURE -- requirements
Module: trigger_measure

---
 rtl/delay_unit_pkg.sv | 20 ++
 rtl/sat_counter.sv | 43 ++++
 rtl/trigger_measure.sv | 155 +++++++++++++++
 tb/tb_trigger_measure.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_unit_pkg.sv
// Shared types and constants for the trigger-to-response delay/width measurement block.
package delay_unit_pkg;

    localparam int unsigned COUNT_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_WAIT_RISE  = 2'd2,
        ST_WAIT_FALL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CNT_HOLD     = 2'd0,
        CNT_CLEAR    = 2'd1,
        CNT_LOAD_ONE = 2'd2,
        CNT_INC      = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/sat_counter.sv
// Cycle counter with clear, load-one and saturating increment; holds when idle.
module sat_counter
    import delay_unit_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cnt_op_e          op_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case (op_i)
            CNT_CLEAR:    count_d = '0;
            CNT_LOAD_ONE: count_d = WIDTH'(1);
            CNT_INC: begin
                // Sticks at all-ones instead of wrapping back to a small count.
                if (count_q != ALL_ONES) begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/trigger_measure.sv
// Measures start_in-to-sense rise delay and sense high width in clock cycles,
// with an optional per-phase timeout.
module trigger_measure
    import delay_unit_pkg::*;
#(
    parameter int unsigned COUNT_BITS = COUNT_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  start_in,
    input  logic                  sense_in,
    input  logic [COUNT_BITS-1:0] timeout_cycles,
    output logic [COUNT_BITS-1:0] delay_cycles,
    output logic [COUNT_BITS-1:0] width_cycles,
    output logic                  result_valid,
    output logic                  timed_out,
    output logic                  busy
);

    state_e state_q;
    state_e state_d;

    logic                  sense_prev_q;
    logic [COUNT_BITS-1:0] delay_q;
    logic [COUNT_BITS-1:0] delay_d;
    logic [COUNT_BITS-1:0] width_q;
    logic [COUNT_BITS-1:0] width_d;
    logic                  result_valid_q;
    logic                  result_valid_d;
    logic                  timed_out_q;
    logic                  timed_out_d;
    logic                  busy_q;
    logic                  busy_d;

    cnt_op_e               dly_op;
    cnt_op_e               wid_op;
    logic [COUNT_BITS-1:0] dly_cnt;
    logic [COUNT_BITS-1:0] wid_cnt;

    logic rise_c;
    logic tmo_en_c;
    logic dly_tmo_c;
    logic wid_tmo_c;

    sat_counter #(
        .WIDTH (COUNT_BITS)
    ) u_delay_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (dly_op),
        .count_o (dly_cnt)
    );

    sat_counter #(
        .WIDTH (COUNT_BITS)
    ) u_width_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (wid_op),
        .count_o (wid_cnt)
    );

    // A level that was already high in the previous cycle never counts as a rise.
    assign rise_c    = sense_in & ~sense_prev_q;
    assign tmo_en_c  = (timeout_cycles != '0);
    assign dly_tmo_c = tmo_en_c && (dly_cnt == timeout_cycles);
    assign wid_tmo_c = tmo_en_c && (wid_cnt == timeout_cycles);

    always_comb begin
        state_d        = state_q;
        dly_op         = CNT_HOLD;
        wid_op         = CNT_HOLD;
        delay_d        = delay_q;
        width_d        = width_q;
        result_valid_d = 1'b0;
        timed_out_d    = timed_out_q;

        if (arm) begin
            state_d     = ST_WAIT_START;
            dly_op      = CNT_CLEAR;
            wid_op      = CNT_CLEAR;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_START: begin
                    if (start_in) begin
                        // Rise coincident with start: delay stays at its cleared zero.
                        if (rise_c) begin
                            state_d = ST_WAIT_FALL;
                            wid_op  = CNT_LOAD_ONE;
                        end else begin
                            state_d = ST_WAIT_RISE;
                            dly_op  = CNT_LOAD_ONE;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise_c) begin
                        state_d = ST_WAIT_FALL;
                        wid_op  = CNT_LOAD_ONE;
                    end else if (dly_tmo_c) begin
                        state_d     = ST_IDLE;
                        timed_out_d = 1'b1;
                    end else begin
                        dly_op = CNT_INC;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!sense_in) begin
                        state_d        = ST_IDLE;
                        delay_d        = dly_cnt;
                        width_d        = wid_cnt;
                        result_valid_d = 1'b1;
                    end else if (wid_tmo_c) begin
                        state_d     = ST_IDLE;
                        timed_out_d = 1'b1;
                    end else begin
                        wid_op = CNT_INC;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sense_prev_q   <= 1'b0;
            delay_q        <= '0;
            width_q        <= '0;
            result_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sense_prev_q   <= sense_in;
            delay_q        <= delay_d;
            width_q        <= width_d;
            result_valid_q <= result_valid_d;
            timed_out_q    <= timed_out_d;
            busy_q         <= busy_d;
        end
    end

    assign delay_cycles = delay_q;
    assign width_cycles = width_q;
    assign result_valid = result_valid_q;
    assign timed_out    = timed_out_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_trigger_measure.sv
// Self-checking bench for trigger_measure: directed corner cases plus randomized
// measurements checked against a waveform-level reference model.
module tb_trigger_measure;

    localparam int unsigned CB   = 5;
    localparam int          MAXV = 31;
    localparam int          SLEN = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          start_in;
    logic          sense_in;
    logic [CB-1:0] timeout_cycles;
    logic [CB-1:0] delay_cycles;
    logic [CB-1:0] width_cycles;
    logic          result_valid;
    logic          timed_out;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int exp_delay = 0;
    int exp_width = 0;

    trigger_measure #(
        .COUNT_BITS (CB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .start_in       (start_in),
        .sense_in       (sense_in),
        .timeout_cycles (timeout_cycles),
        .delay_cycles   (delay_cycles),
        .width_cycles   (width_cycles),
        .result_valid   (result_valid),
        .timed_out      (timed_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_busy, input int e_rv, input int e_to);
        chk({tag, ".busy"},  32'(busy),         32'(e_busy));
        chk({tag, ".rv"},    32'(result_valid), 32'(e_rv));
        chk({tag, ".to"},    32'(timed_out),    32'(e_to));
        chk({tag, ".delay"}, 32'(delay_cycles), 32'(exp_delay));
        chk({tag, ".width"}, 32'(width_cycles), 32'(exp_width));
    endtask

    // One measurement: arm at cycle 0, start at t0 = 1+g. The expected outcome is
    // derived from the sense waveform alone: first 0->1 at/after t0, next 1->0 after it.
    task automatic run_meas(input bit p, input int g, input int h, input int rrel,
                            input int w, input int tmo, input string tag);
        logic s [0:SLEN-1];
        int   t0, r, f, e, nd, nw;
        bit   to;
        t0 = 1 + g;
        for (int i = 0; i < SLEN; i++) s[i] = 1'b0;
        for (int i = 0; i < t0; i++) s[i] = p;
        if (p) for (int j = 0; j < h; j++) s[t0 + j] = 1'b1;
        for (int j = 0; j < w; j++) s[t0 + rrel + j] = 1'b1;

        r = -1;
        f = -1;
        for (int i = t0; i < SLEN; i++) if (r < 0 && s[i] && !s[i-1]) r = i;
        if (r >= 0) for (int i = r + 1; i < SLEN; i++) if (f < 0 && !s[i]) f = i;

        to = 1'b0;
        if (tmo != 0 && (r < 0 || r - t0 > tmo)) begin
            e  = t0 + tmo;
            to = 1'b1;
        end else if (tmo != 0 && f - r > tmo) begin
            e  = r + tmo;
            to = 1'b1;
        end else begin
            e = f;
        end
        nd = (r - t0 > MAXV) ? MAXV : r - t0;
        nw = (f - r > MAXV) ? MAXV : f - r;

        arm            = 1'b0;
        start_in       = 1'b0;
        sense_in       = p;
        timeout_cycles = CB'(tmo);
        tick();
        for (int i = 0; i <= e + 2; i++) begin
            arm      = (i == 0);
            start_in = (i == t0) || (i == 0 && ($urandom % 2) == 1)
                       || (i > t0 && $urandom_range(0, 7) == 0);
            sense_in = (i < SLEN) ? s[i] : 1'b0;
            tick();
            if (!to && i == e) begin
                exp_delay = nd;
                exp_width = nw;
            end
            chk_all($sformatf("%s@%0d", tag, i), int'(i < e), int'(i == e && !to),
                    int'(to && i >= e));
        end
        arm      = 1'b0;
        start_in = 1'b0;
        sense_in = 1'b0;
    endtask

    initial begin
        int p, g, h, rrel, w, tmo;
        rst_n          = 1'b0;
        arm            = 1'b0;
        start_in       = 1'b0;
        sense_in       = 1'b0;
        timeout_cycles = '0;
        #12;
        chk_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0);

        run_meas(1'b0, 1, 0, 10, 3, 0, "basic");
        run_meas(1'b0, 0, 0, 0, 1, 0, "same_cycle");
        run_meas(1'b0, 2, 0, 0, 0, 5, "tmo_rise");
        run_meas(1'b1, 1, 1, 4, 3, 0, "pre_high");
        run_meas(1'b0, 1, 0, 5, 3, 5, "tmo_eq_rise");
        run_meas(1'b0, 0, 0, 2, 4, 4, "tmo_eq_fall");
        run_meas(1'b0, 0, 0, 2, 5, 4, "tmo_width");
        run_meas(1'b0, 0, 0, 35, 34, 0, "saturate");
        run_meas(1'b0, 0, 0, 0, 0, 31, "tmo_max");

        // Abort in WAIT_FALL: the interrupted pulse must never produce a result.
        timeout_cycles = '0;
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        sense_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("abort@%0d", i), 1, 0, 0);
        end
        run_meas(1'b1, 0, 2, 7, 2, 0, "rearm");

        // Timeout raised mid-phase takes effect from the next cycle.
        timeout_cycles = '0;
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_all($sformatf("tmo_change@%0d", i), 1, 0, 0);
        end
        timeout_cycles = CB'(6);
        tick();
        chk_all("tmo_change@4", 1, 0, 0);
        tick();
        chk_all("tmo_change@5", 1, 0, 0);
        tick();
        chk_all("tmo_change@6", 0, 0, 1);

        for (int k = 0; k < 25; k++) begin
            p    = int'($urandom % 2);
            g    = int'($urandom_range(0, 3));
            rrel = (($urandom % 4) == 0) ? int'($urandom_range(32, 40))
                                         : int'($urandom_range(0, 20));
            if (rrel == 0) p = 0;
            h    = (p == 1) ? int'($urandom_range(0, (rrel - 1 < 2) ? rrel - 1 : 2)) : 0;
            w    = (($urandom % 4) == 0) ? int'($urandom_range(30, 40))
                                         : int'($urandom_range(1, 12));
            tmo  = (($urandom % 3) == 0) ? 0 : int'($urandom_range(1, 31));
            run_meas(p[0], g, h, rrel, w, tmo, $sformatf("rand%0d", k));
        end

        // Asynchronous reset in the middle of WAIT_RISE.
        timeout_cycles = '0;
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        chk("rst_pre.busy", 32'(busy), 32'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_delay = 0;
        exp_width = 0;
        chk_all("rst_async", 0, 0, 0);
        tick();
        chk_all("rst_hold", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk_all("rst_noarm0", 0, 0, 0);
        sense_in = 1'b1;
        tick();
        sense_in = 1'b0;
        tick();
        chk_all("rst_noarm1", 0, 0, 0);
        tick();
        chk_all("rst_noarm2", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
